// File: rtl/tag_lock_queue_pkg.sv
// tag_lock_queue_pkg: shared width helpers for the tag lock queue and its arbiter.
package tag_lock_queue_pkg;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    localparam int NUM_COL_DEF = 4;
    localparam int NUM_CH_DEF  = 4;
    localparam int TAG_W_DEF   = clog2_min1(NUM_COL_DEF);
    localparam int CH_W_DEF    = clog2_min1(NUM_CH_DEF);
endpackage

// File: rtl/tag_lock_queue_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting the search at ptr_i.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] grant_idx_o,
    output logic         any_o
);
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_o                              = 1'b1;
                grant_o[(int'(ptr_i) + k) % N]     = 1'b1;
                grant_idx_o                        = W'((int'(ptr_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/tag_lock_queue.sv
// tag_lock_queue: per-lane first-flush tag capture with lock, queued as {lane, tag}
// in round-robin arrival order and drained over valid/ready.
module tag_lock_queue
    import tag_lock_queue_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 4,
    parameter int AUTO_REARM = 1,
    localparam int TAG_W     = clog2_min1(NUM_COL),
    localparam int CH_W      = clog2_min1(NUM_CH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear_i,
    input  logic [NUM_CH-1:0]       flush_i,
    input  logic [NUM_CH*TAG_W-1:0] tag_in_i,
    input  logic [NUM_CH-1:0]       release_i,
    output logic [NUM_CH-1:0]       tag_lock_o,
    output logic [NUM_CH*TAG_W-1:0] held_tag_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [TAG_W-1:0]        out_tag_o,
    output logic [CH_W-1:0]         out_ch_o,
    output logic [CNT_W-1:0]        count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = CH_W + TAG_W;

    logic [NUM_CH-1:0]       lock_q, lock_d, pend_q, pend_d, infl_q, infl_d;
    logic [NUM_CH-1:0]       grant, capture, pop_mask, rel_unl, pop_unl;
    logic [NUM_CH*TAG_W-1:0] held_q, held_d;
    logic [CH_W-1:0]         rr_q, rr_d, gidx;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0]           mem_q [DEPTH];
    logic [EW-1:0]           head;
    logic                    any, push, pop, full, empty;

    if (DEPTH < NUM_CH) begin : g_depth_check
        $error("DEPTH must be >= NUM_CH");
    end

    rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
        .req_i       (pend_q),
        .ptr_i       (rr_q),
        .grant_o     (grant),
        .grant_idx_o (gidx),
        .any_o       (any)
    );

    assign head     = mem_q[rd_q[AW-1:0]];
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push     = any & ~clear_i;
    assign pop      = ~empty & out_ready_i & ~clear_i;
    assign pop_mask = pop ? (NUM_CH'(1) << head[EW-1 -: CH_W]) : '0;
    assign rel_unl  = (AUTO_REARM != 0) ? '0 : (release_i & ~infl_q);
    assign pop_unl  = (AUTO_REARM != 0) ? pop_mask : '0;
    // A release in the same cycle makes the lane capturable, so the flush wins over the unlock
    assign capture  = flush_i & (~lock_q | rel_unl) & {NUM_CH{~clear_i}};

    always_comb begin
        held_d = held_q;
        for (int i = 0; i < NUM_CH; i++)
            if (capture[i]) held_d[i*TAG_W +: TAG_W] = tag_in_i[i*TAG_W +: TAG_W];
        lock_d = clear_i ? '0 : (lock_q & ~(rel_unl | pop_unl)) | capture;
        pend_d = clear_i ? '0 : (pend_q & ~grant) | capture;
        infl_d = clear_i ? '0 : (infl_q & ~pop_mask) | capture;
        rr_d   = clear_i ? '0 : push ? ((int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1) : rr_q;
        wr_d   = clear_i ? '0 : wr_q + PW'(push);
        rd_d   = clear_i ? '0 : rd_q + PW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q <= '0;
            pend_q <= '0;
            infl_q <= '0;
            held_q <= '0;
            rr_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
        end else begin
            lock_q <= lock_d;
            pend_q <= pend_d;
            infl_q <= infl_d;
            held_q <= held_d;
            rr_q   <= rr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {gidx, held_q[gidx*TAG_W +: TAG_W]};
    end

    assign tag_lock_o  = lock_q;
    assign held_tag_o  = held_q;
    assign out_valid_o = ~empty;
    assign out_tag_o   = head[TAG_W-1:0];
    assign out_ch_o    = head[EW-1 -: CH_W];
    assign count_o     = CNT_W'(wr_q - rd_q);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));
endmodule

// File: tb/tb_tag_lock_queue.sv
// tb_tag_lock_queue: table-driven and sequence checks of tag_lock_queue with a pop scoreboard.
module tb_tag_lock_queue;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clear = 1'b0, out_ready = 1'b0;
    logic [3:0] flush = '0, rel = '0;
    logic [7:0] tag_in = '0;
    logic [3:0] a_lock, b_lock;
    logic [7:0] a_held, b_held;
    logic       a_valid, b_valid;
    logic [1:0] a_tag, b_tag, a_ch, b_ch;
    logic [2:0] a_cnt, b_cnt;
    int         checks = 0, fails = 0;
    logic       mon_en = 1'b1;

    typedef struct {logic [1:0] ch; logic [1:0] tag;} ent_t;
    typedef struct {
        logic [3:0] flush; logic [7:0] tag; logic ready;
        logic push; logic [1:0] pch; logic [1:0] ptag;
        logic [3:0] lock; logic [7:0] held; logic [2:0] cnt; logic valid;
    } vec_t;
    ent_t sb[$];
    ent_t mon_e;
    vec_t vt[14];

    always #5 clk = ~clk;

    tag_lock_queue #(.AUTO_REARM(1)) dut_a (
        .clk(clk), .rstn(rstn), .clear_i(clear), .flush_i(flush), .tag_in_i(tag_in),
        .release_i(rel), .tag_lock_o(a_lock), .held_tag_o(a_held), .out_valid_o(a_valid),
        .out_ready_i(out_ready), .out_tag_o(a_tag), .out_ch_o(a_ch), .count_o(a_cnt));

    tag_lock_queue #(.AUTO_REARM(0)) dut_b (
        .clk(clk), .rstn(rstn), .clear_i(clear), .flush_i(flush), .tag_in_i(tag_in),
        .release_i(rel), .tag_lock_o(b_lock), .held_tag_o(b_held), .out_valid_o(b_valid),
        .out_ready_i(out_ready), .out_tag_o(b_tag), .out_ch_o(b_ch), .count_o(b_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; clear = 1'b0; flush = '0; rel = '0; tag_in = '0; out_ready = 1'b0;
        repeat (2) tick();
        #1 rstn = 1'b1;
        sb.delete();
    endtask

    task automatic push_sb(input logic [1:0] ch, input logic [1:0] tag);
        sb.push_back('{ch: ch, tag: tag});
    endtask

    task automatic drain();
        out_ready = 1'b1; flush = '0;
        repeat (8) begin tick(); #1; end
        chk("drain_cnt", a_cnt, 0);
        chk("sb_empty", sb.size(), 0);
        out_ready = 1'b0;
    endtask

    // Pop monitor: inputs for the coming edge are settled, outputs reflect the last edge
    always @(negedge clk) begin
        #2;
        if (mon_en && rstn && !clear && a_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL sb_underflow actual_ch=%0d actual_tag=%0d required=none", a_ch, a_tag);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_ch", a_ch, mon_e.ch);
                chk("pop_tag", a_tag, mon_e.tag);
            end
        end
    end

    initial begin
        //          flush   tag    rdy  push ch tg  lock   held   cnt v
        vt[0]  = '{4'b0001, 8'h02, 1, 1, 0, 2, 4'b0001, 8'h02, 0, 0};
        vt[1]  = '{4'b0000, 8'h00, 1, 0, 0, 0, 4'b0001, 8'h02, 1, 1};
        vt[2]  = '{4'b0000, 8'h00, 1, 0, 0, 0, 4'b0000, 8'h02, 0, 0};
        vt[3]  = '{4'b0010, 8'h0C, 0, 1, 1, 3, 4'b0010, 8'h0E, 0, 0};
        vt[4]  = '{4'b0010, 8'h00, 0, 0, 0, 0, 4'b0010, 8'h0E, 1, 1};
        vt[5]  = '{4'b0000, 8'h00, 0, 0, 0, 0, 4'b0010, 8'h0E, 1, 1};
        vt[6]  = '{4'b0000, 8'h00, 1, 0, 0, 0, 4'b0000, 8'h0E, 0, 0};
        vt[7]  = '{4'b0010, 8'h04, 0, 1, 1, 1, 4'b0010, 8'h06, 0, 0};
        vt[8]  = '{4'b0000, 8'h00, 0, 0, 0, 0, 4'b0010, 8'h06, 1, 1};
        vt[9]  = '{4'b0010, 8'h08, 1, 0, 0, 0, 4'b0000, 8'h06, 0, 0};
        vt[10] = '{4'b0000, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h06, 0, 0};
        vt[11] = '{4'b0001, 8'h01, 0, 1, 0, 1, 4'b0001, 8'h05, 0, 0};
        vt[12] = '{4'b0000, 8'h00, 1, 0, 0, 0, 4'b0001, 8'h05, 1, 1};
        vt[13] = '{4'b0000, 8'h00, 1, 0, 0, 0, 4'b0000, 8'h05, 0, 0};

        do_reset();
        chk("rst_a_lock", a_lock, 0);  chk("rst_a_held", a_held, 0);
        chk("rst_a_valid", a_valid, 0); chk("rst_a_cnt", a_cnt, 0);
        chk("rst_b_lock", b_lock, 0);  chk("rst_b_valid", b_valid, 0);

        // capture, lock, ignore-while-locked, unlock on pop
        for (int i = 0; i < 14; i++) begin
            flush = vt[i].flush; tag_in = vt[i].tag; out_ready = vt[i].ready;
            if (vt[i].push) push_sb(vt[i].pch, vt[i].ptag);
            tick();
            chk($sformatf("vec%0d_lock", i), a_lock, vt[i].lock);
            chk($sformatf("vec%0d_held", i), a_held, vt[i].held);
            chk($sformatf("vec%0d_cnt", i), a_cnt, vt[i].cnt);
            chk($sformatf("vec%0d_valid", i), a_valid, vt[i].valid);
            #1;
        end
        chk("vec_sb_empty", sb.size(), 0);

        // simultaneous burst: round-robin order and pointer carry-over
        do_reset();
        flush = 4'b1111; tag_in = 8'hE4; out_ready = 1'b0;
        push_sb(0, 0); push_sb(1, 1); push_sb(2, 2); push_sb(3, 3);
        tick(); chk("burst_cnt0", a_cnt, 0); chk("burst_lock", a_lock, 4'b1111);
        #1 flush = '0;
        for (int k = 1; k <= 4; k++) begin
            tick(); chk($sformatf("burst_cnt%0d", k), a_cnt, k[2:0]); #1;
        end
        drain();
        flush = 4'b0010; tag_in = 8'h08; push_sb(1, 2);
        tick(); #1 flush = '0;
        drain();
        flush = 4'b1111; tag_in = 8'h1B;
        push_sb(2, 1); push_sb(3, 0); push_sb(0, 3); push_sb(1, 2);
        tick(); #1 flush = '0;
        repeat (4) tick();
        chk("burst2_cnt", a_cnt, 4);
        #1 drain();

        // manual release mode on dut_b
        mon_en = 1'b0;
        do_reset();
        flush = 4'b0100; tag_in = 8'h30;
        tick(); chk("b_cap_lock", b_lock, 4'b0100);
        #1 flush = '0; rel = 4'b0100;
        tick(); chk("b_rel_inflight_lock", b_lock, 4'b0100); chk("b_cnt1", b_cnt, 1);
        #1 rel = '0; out_ready = 1'b1;
        tick(); chk("b_pop_cnt", b_cnt, 0); chk("b_pop_lock", b_lock, 4'b0100);
        #1 out_ready = 1'b0; rel = 4'b0100; flush = 4'b0100; tag_in = 8'h10;
        tick(); chk("b_race_lock", b_lock, 4'b0100); chk("b_race_held", b_held[5:4], 1);
        #1 rel = '0; flush = '0;
        tick(); chk("b_race_cnt", b_cnt, 1);
        #1 out_ready = 1'b1;
        tick(); chk("b_pop2_cnt", b_cnt, 0); chk("b_pop2_lock", b_lock, 4'b0100);
        #1 out_ready = 1'b0; rel = 4'b0100;
        tick(); chk("b_release_lock", b_lock, 0);
        #1 rel = '0;
        mon_en = 1'b1;

        // clear beats capture, held_tag retained
        do_reset();
        flush = 4'b0111; tag_in = 8'h39;
        tick(); #1 flush = '0;
        repeat (3) tick();
        chk("clr_pre_cnt", a_cnt, 3); chk("clr_pre_lock", a_lock, 4'b0111);
        #1 clear = 1'b1; flush = 4'b1001; tag_in = 8'hB9;
        tick();
        chk("clr_cnt", a_cnt, 0); chk("clr_valid", a_valid, 0);
        chk("clr_lock", a_lock, 0); chk("clr_held", a_held, 8'h39);
        #1 clear = 1'b0; flush = '0;
        tick(); chk("clr_post_cnt", a_cnt, 0); chk("clr_post_lock", a_lock, 0);

        // asynchronous reset mid-operation
        do_reset();
        flush = 4'b0011; tag_in = 8'h06;
        tick(); #1 flush = '0;
        repeat (2) tick();
        chk("ar_pre_cnt", a_cnt, 2); chk("ar_pre_valid", a_valid, 1);
        #3 rstn = 1'b0;
        #1;
        chk("ar_valid", a_valid, 0); chk("ar_cnt", a_cnt, 0); chk("ar_lock", a_lock, 0);
        tick(); #1 rstn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
